// File: rtl/pc_sequencer_if.sv
// Fetch-side bus between the PC sequencer and its control/imem neighbours.
// slave = the sequencer, master = whatever drives decode/imem controls.
interface pc_sequencer_if;
    logic        imemReady;
    logic        stall;
    logic        branchEn;
    logic        branchTaken;
    logic        jumpEn;
    logic        jumpRegEn;
    logic [31:0] signedImmediate;
    logic [25:0] jumpIndex;
    logic [31:0] regTarget;
    logic        fetchValid;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        misaligned;

    // Handshake: a fetch at pc is accepted on a rising edge where
    // fetchValid = 1, imemReady = 1 and stall = 0; only then are controls used.
    modport slave (
        input  imemReady, stall, branchEn, branchTaken, jumpEn, jumpRegEn,
        input  signedImmediate, jumpIndex, regTarget,
        output fetchValid, pc, pcPlus4, misaligned
    );

    modport master (
        output imemReady, stall, branchEn, branchTaken, jumpEn, jumpRegEn,
        output signedImmediate, jumpIndex, regTarget,
        input  fetchValid, pc, pcPlus4, misaligned
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/FETCH/HALT FSM with jr/j/branch redirects.
// Define BRANCH_DELAY_SLOT_EN for MIPS delay-slot semantics (pending target).
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              resetN,
    pc_sequencer_if.slave     bus,
    output logic [1:0]        dbgState
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } stateT;

    stateT       state;
    logic [31:0] pcReg;
    logic        fetchValidReg;
    logic        misalignedReg;
    logic [31:0] pcPlus4;
    logic [31:0] branchTarget;
    logic [31:0] jumpTarget;
    logic [31:0] redirectTarget;
    logic        redirect;
    logic        jrMisaligned;
    logic        advance;

`ifdef BRANCH_DELAY_SLOT_EN
    logic        pendingValid;
    logic [31:0] pendingTarget;
`endif

    always_comb begin
        pcPlus4      = pcReg + 32'd4;
        branchTarget = pcPlus4 + (bus.signedImmediate << 2);
        jumpTarget   = {pcPlus4[31:28], bus.jumpIndex, 2'b00};
        redirect     = bus.jumpRegEn | bus.jumpEn | (bus.branchEn & bus.branchTaken);
        jrMisaligned = bus.jumpRegEn && (bus.regTarget[1:0] != 2'b00);
        advance      = (state == FETCH) && bus.imemReady && !bus.stall;
        if (bus.jumpRegEn)
            redirectTarget = bus.regTarget;
        else if (bus.jumpEn)
            redirectTarget = jumpTarget;
        else
            redirectTarget = branchTarget;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE;
            pcReg         <= RESET_VECTOR;
            fetchValidReg <= 1'b0;
            misalignedReg <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
            pendingValid  <= 1'b0;
            pendingTarget <= 32'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state         <= FETCH;
                    pcReg         <= RESET_VECTOR;
                    fetchValidReg <= 1'b1;
                end
                FETCH: begin
                    if (advance) begin
`ifdef BRANCH_DELAY_SLOT_EN
                        // The delay-slot advance only consumes the pending target.
                        if (pendingValid) begin
                            pcReg        <= pendingTarget;
                            pendingValid <= 1'b0;
                        end else if (jrMisaligned) begin
                            state         <= HALT;
                            fetchValidReg <= 1'b0;
                            misalignedReg <= 1'b1;
                        end else if (redirect) begin
                            pendingTarget <= redirectTarget;
                            pendingValid  <= 1'b1;
                            pcReg         <= pcPlus4;
                        end else begin
                            pcReg <= pcPlus4;
                        end
`else
                        // A misaligned jr halts with pc still at the jr itself.
                        if (jrMisaligned) begin
                            state         <= HALT;
                            fetchValidReg <= 1'b0;
                            misalignedReg <= 1'b1;
                        end else if (redirect) begin
                            pcReg <= redirectTarget;
                        end else begin
                            pcReg <= pcPlus4;
                        end
`endif
                    end
                end
                HALT: begin
                    fetchValidReg <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    fetchValidReg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc         = pcReg;
    assign bus.pcPlus4    = pcPlus4;
    assign bus.fetchValid = fetchValidReg;
    assign bus.misaligned = misalignedReg;
    assign dbgState       = state;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expectations are hand-computed addresses.
// Works in both configurations (BRANCH_DELAY_SLOT_EN defined or not).
module tb_pc_sequencer;
    logic       clk = 1'b0;
    logic       resetN;
    logic [1:0] dbgState;
    int         compared   = 0;
    int         mismatched = 0;

    pc_sequencer_if bus();

    pc_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk      (clk),
        .resetN   (resetN),
        .bus      (bus),
        .dbgState (dbgState)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearCtl();
        bus.stall           = 1'b0;
        bus.branchEn        = 1'b0;
        bus.branchTaken     = 1'b0;
        bus.jumpEn          = 1'b0;
        bus.jumpRegEn       = 1'b0;
        bus.signedImmediate = 32'h0;
        bus.jumpIndex       = 26'h0;
        bus.regTarget       = 32'h0;
    endtask

    // Controls stay asserted through the delay slot to show they are ignored there.
    task automatic takeRedirect(input string tag, input logic [31:0] fromPc, input logic [31:0] target);
        step();
`ifdef BRANCH_DELAY_SLOT_EN
        check({tag, "_slot"}, bus.pc, fromPc + 32'd4);
        step();
`endif
        check(tag, bus.pc, target);
        clearCtl();
    endtask

    initial begin
        resetN        = 1'b0;
        bus.imemReady = 1'b0;
        clearCtl();
        #3;
        check("reset_pc", bus.pc, 32'h0);
        check("reset_fv", {31'h0, bus.fetchValid}, 32'h0);
        check("reset_mis", {31'h0, bus.misaligned}, 32'h0);
        check("reset_state", {30'h0, dbgState}, 32'h0);
        step();
        check("reset_hold_state", {30'h0, dbgState}, 32'h0);

        // Release between edges, then sequential fetch 0, 4, 8.
        resetN        = 1'b1;
        bus.imemReady = 1'b1;
        check("rel_fv", {31'h0, bus.fetchValid}, 32'h0);
        step();
        check("seq0_pc", bus.pc, 32'h0);
        check("seq0_fv", {31'h0, bus.fetchValid}, 32'h1);
        check("seq0_state", {30'h0, dbgState}, 32'h1);
        step();
        check("seq1_pc", bus.pc, 32'h4);
        check("seq1_p4", bus.pcPlus4, 32'h8);
        step();
        check("seq2_pc", bus.pc, 32'h8);

        bus.jumpEn = 1'b1; bus.jumpIndex = 26'h40;
        takeRedirect("jump", 32'h8, 32'h100);

        bus.branchEn = 1'b1; bus.branchTaken = 1'b1; bus.signedImmediate = 32'hFFFF_FFFF;
        takeRedirect("br_back", 32'h100, 32'h100);

        // branchTaken without branchEn is sequential
        bus.branchTaken = 1'b1; bus.signedImmediate = 32'h10;
        step();
        check("bt_noen", bus.pc, 32'h104);
        clearCtl();

        bus.branchEn = 1'b1; bus.signedImmediate = 32'h10; bus.imemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.branchTaken = i[0];
            step();
            check("nordy_hold", bus.pc, 32'h104);
        end
        bus.imemReady = 1'b1; bus.stall = 1'b1; bus.branchTaken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_hold", bus.pc, 32'h104);
        end
        clearCtl();
        step();
        check("post_stall", bus.pc, 32'h108);

        bus.jumpRegEn = 1'b1; bus.regTarget = 32'h1000_0010;
        takeRedirect("jr", 32'h108, 32'h1000_0010);

        bus.jumpEn = 1'b1; bus.jumpRegEn = 1'b1; bus.regTarget = 32'h40;
        bus.jumpIndex = 26'h3FF_FFFF; bus.branchEn = 1'b1; bus.branchTaken = 1'b1;
        bus.signedImmediate = 32'h100;
        takeRedirect("prio_jr", 32'h1000_0010, 32'h40);

        bus.jumpEn = 1'b1; bus.jumpIndex = 26'h80;
        bus.branchEn = 1'b1; bus.branchTaken = 1'b1; bus.signedImmediate = 32'h10;
        takeRedirect("prio_j", 32'h40, 32'h200);

        bus.jumpRegEn = 1'b1; bus.regTarget = 32'hFFFF_FFFC;
        takeRedirect("jr_top", 32'h200, 32'hFFFF_FFFC);
        check("top_p4", bus.pcPlus4, 32'h0);
        step();
        check("seq_wrap", bus.pc, 32'h0);

        bus.branchEn = 1'b1; bus.branchTaken = 1'b1; bus.signedImmediate = 32'hFFFF_FFFE;
        takeRedirect("br_wrap", 32'h0, 32'hFFFF_FFFC);
        step();
        check("seq_wrap2", bus.pc, 32'h0);

        // Reset right after a redirect advance must drop any pending target.
        bus.jumpEn = 1'b1; bus.jumpIndex = 26'h100;
        step();
`ifdef BRANCH_DELAY_SLOT_EN
        check("rst_pre", bus.pc, 32'h4);
`else
        check("rst_pre", bus.pc, 32'h400);
`endif
        #2;
        resetN = 1'b0;
        #1;
        check("async_pc", bus.pc, 32'h0);
        check("async_fv", {31'h0, bus.fetchValid}, 32'h0);
        check("async_state", {30'h0, dbgState}, 32'h0);
        clearCtl();
        step();
        check("async_hold", bus.pc, 32'h0);
        resetN = 1'b1;
        step();
        check("rerel_pc0", bus.pc, 32'h0);
        step();
        check("rerel_pc4", bus.pc, 32'h4);

        bus.jumpRegEn = 1'b1; bus.regTarget = 32'h42;
        step();
        check("mis_pc", bus.pc, 32'h4);
        check("mis_flag", {31'h0, bus.misaligned}, 32'h1);
        check("mis_fv", {31'h0, bus.fetchValid}, 32'h0);
        check("mis_state", {30'h0, dbgState}, 32'h2);
        clearCtl();
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_pc", bus.pc, 32'h4);
            check("halt_state", {30'h0, dbgState}, 32'h2);
        end
        #2;
        resetN = 1'b0;
        #1;
        check("halt_rst_pc", bus.pc, 32'h0);
        check("halt_rst_mis", {31'h0, bus.misaligned}, 32'h0);
        check("halt_rst_state", {30'h0, dbgState}, 32'h0);
        resetN = 1'b1;
        step();
        check("post_halt_pc", bus.pc, 32'h0);
        check("post_halt_fv", {31'h0, bus.fetchValid}, 32'h1);
        step();
        check("post_halt_pc4", bus.pc, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
